// File: rtl/pc_select_pkg.sv
// Shared constants for the fetch-stage PC select unit: next-PC source encodings and the sequential step.
package pc_select_pkg;

  localparam logic [2:0] PC_SRC_SEQ    = 3'b000;
  localparam logic [2:0] PC_SRC_BRANCH = 3'b001;
  localparam logic [2:0] PC_SRC_JUMP   = 3'b010;
  localparam logic [2:0] PC_SRC_REG    = 3'b011;
  localparam logic [2:0] PC_SRC_EXC    = 3'b100;
  localparam logic [2:0] PC_SRC_RET    = 3'b101;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_select_unit_if.sv
// Control-unit <-> PC unit bundle: source select, stall, call, targets, and PC/stack status back.
interface pc_select_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             stall;
  logic [2:0]       control;
  logic             call;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] reg_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] next_pc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;

  modport master (
    output stall, control, call, branch_target, jump_target, reg_target,
    input  pc, pc_plus4, next_pc, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, control, call, branch_target, jump_target, reg_target,
    output pc, pc_plus4, next_pc, ras_empty, ras_full, ras_underflow
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry and the count saturates.
module pc_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_c;

  assign top   = mem[top_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Push with pop replaces the top in place; a plain push writes above it.
  assign wr_ptr_c = pop ? top_q : top_q + PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (push && !pop) begin
      top_q <= top_q + PTR_W'(1);
      if (!full) count_q <= count_q + CNT_W'(1);
    end else if (pop && !push) begin
      top_q   <= top_q - PTR_W'(1);
      count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_c] <= push_data;
  end

endmodule

// File: rtl/pc_select_unit.sv
// Registered fetch PC with six next-PC sources, stall and exception override.
// Optional return-address stack built when PC_SELECT_RAS_EN is defined.
module pc_select_unit
  import pc_select_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]      EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic             clk,
  input logic             reset,
  pc_select_unit_if.slave bus
);

  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_plus4_c;
  logic [WIDTH-1:0] sel_pc_c;
  logic [WIDTH-1:0] next_pc_c;
  logic [WIDTH-1:0] ret_pc_c;
  logic             is_exc_c;
  logic             is_ret_c;
  logic             ras_empty_c;
  logic             ras_full_c;
  logic             ras_underflow_r;

  assign is_exc_c   = (bus.control == PC_SRC_EXC);
  assign is_ret_c   = (bus.control == PC_SRC_RET);
  assign pc_plus4_c = pc_q + WIDTH'(PC_INC);

  // Source select; reserved encodings fall through to sequential.
  always_comb begin
    sel_pc_c = pc_plus4_c;
    case (bus.control)
      PC_SRC_SEQ:    sel_pc_c = pc_plus4_c;
      PC_SRC_BRANCH: sel_pc_c = bus.branch_target;
      PC_SRC_JUMP:   sel_pc_c = bus.jump_target;
      PC_SRC_REG:    sel_pc_c = bus.reg_target;
      PC_SRC_EXC:    sel_pc_c = EXC_PC;
      PC_SRC_RET:    sel_pc_c = ret_pc_c;
      default:       sel_pc_c = pc_plus4_c;
    endcase
  end

  // An exception is the only source that gets through a stall.
  assign next_pc_c = (bus.stall && !is_exc_c) ? pc_q : sel_pc_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_VECTOR;
    else       pc_q <= next_pc_c;
  end

`ifdef PC_SELECT_RAS_EN
  logic [WIDTH-1:0] ras_top;
  logic             push_c;
  logic             pop_c;

  assign push_c   = bus.call && !bus.stall && !is_exc_c;
  assign pop_c    = is_ret_c && !bus.stall && !ras_empty_c;
  assign ret_pc_c = ras_empty_c ? bus.reg_target : ras_top;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (WIDTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .pop       (pop_c),
    .clear     (is_exc_c),
    .push_data (pc_plus4_c),
    .top       (ras_top),
    .empty     (ras_empty_c),
    .full      (ras_full_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           ras_underflow_r <= 1'b0;
    else if (is_exc_c)   ras_underflow_r <= 1'b0;
    else if (!bus.stall) ras_underflow_r <= is_ret_c && ras_empty_c;
  end
`else
  logic                unused_call;
  localparam int unsigned unused_ras_depth = RAS_DEPTH;

  assign unused_call     = bus.call;
  assign ret_pc_c        = bus.reg_target;
  assign ras_empty_c     = 1'b1;
  assign ras_full_c      = 1'b0;
  assign ras_underflow_r = 1'b0;
`endif

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4_c;
  assign bus.next_pc       = next_pc_c;
  assign bus.ras_empty     = ras_empty_c;
  assign bus.ras_full      = ras_full_c;
  assign bus.ras_underflow = ras_underflow_r;

endmodule
